// File: rtl/ptmch_reg_poller.sv
// Avalon-MM master for the ptmch register slave: checks the RTL ID, programs the
// four page-address windows, then polls the trigger counters into a coherent snapshot.
module ptmch_reg_poller #(
   parameter int unsigned P_POLL_CYCLES = 100000,
   parameter int unsigned P_TIMEOUT     = 255,
   parameter logic [31:0] P_RTLID       = 32'h5A5A_00FF
) (
   input  logic        CLK100M,
   input  logic        RESET,
   input  logic        START,
   input  logic        STOP,
   input  logic [95:0] CFG_LOW_ADDR,
   input  logic [95:0] CFG_HIGH_ADDR,
   output logic [31:0] PRGEXCT_CNT,
   output logic [31:0] RDSTAT_CNT,
   output logic [31:0] BLKERS_CNT,
   output logic [31:0] PDREAD_CNT,
   output logic        SNAP_VALID,
   output logic        BUSY,
   output logic        ERR_ID,
   output logic        ERR_TIMEOUT,
   output logic        M_BEGINTRANSFER,
   output logic        M_CS,
   output logic        M_READ,
   output logic        M_WRITE,
   output logic [15:0] M_ADDRESS,
   output logic [31:0] M_WRITEDATA,
   input  logic [31:0] M_READDATA,
   input  logic        M_WAITREQUEST
);

   typedef enum logic [2:0] {
      S_IDLE, S_ID_RD, S_CFG_WR, S_POLL_WAIT, S_POLL_RD, S_COMMIT, S_ERROR
   } state_t;

   localparam logic [23:0] WAIT_LOAD = 24'(P_POLL_CYCLES - 1);
   localparam logic [7:0]  TO_LAST   = 8'(P_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic             xfer_q, xfer_d;    // strobes asserted
   logic             beg_q, beg_d;
   logic             gap_q, gap_d;      // mandatory idle cycle after a transfer
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       to_q, to_d;
   logic [23:0]      wait_q, wait_d;
   logic             stop_q, stop_d;
   logic             err_id_q, err_id_d;
   logic             err_to_q, err_to_d;
   logic             snap_q, snap_d;
   logic [95:0]      low_q, low_d, high_q, high_d;
   logic [3:0][31:0] sh_q, sh_d, cnt_q, cnt_d;
   logic [2:0]       last_idx;
   logic             busy;
   logic [95:0]      bank;
   logic [23:0]      win;

   assign busy = (state_q != S_IDLE) && (state_q != S_ERROR);

   // NOTE: every register updates with <= so all of them see pre-edge values.
   always_ff @(posedge CLK100M or posedge RESET) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         xfer_q   <= 1'b0;
         beg_q    <= 1'b0;
         gap_q    <= 1'b0;
         idx_q    <= '0;
         to_q     <= '0;
         wait_q   <= '0;
         stop_q   <= 1'b0;
         err_id_q <= 1'b0;
         err_to_q <= 1'b0;
         snap_q   <= 1'b0;
         low_q    <= '0;
         high_q   <= '0;
         sh_q     <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         xfer_q   <= xfer_d;
         beg_q    <= beg_d;
         gap_q    <= gap_d;
         idx_q    <= idx_d;
         to_q     <= to_d;
         wait_q   <= wait_d;
         stop_q   <= stop_d;
         err_id_q <= err_id_d;
         err_to_q <= err_to_d;
         snap_q   <= snap_d;
         low_q    <= low_d;
         high_q   <= high_d;
         sh_q     <= sh_d;
         cnt_q    <= cnt_d;
      end
   end

   // NOTE: every variable gets a default first so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      xfer_d   = xfer_q;
      beg_d    = 1'b0;
      gap_d    = gap_q;
      idx_d    = idx_q;
      to_d     = to_q;
      wait_d   = wait_q;
      stop_d   = stop_q;
      err_id_d = err_id_q;
      err_to_d = err_to_q;
      snap_d   = 1'b0;
      low_d    = low_q;
      high_d   = high_q;
      sh_d     = sh_q;
      cnt_d    = cnt_q;
      last_idx = (state_q == S_CFG_WR) ? 3'd7 : (state_q == S_POLL_RD) ? 3'd3 : 3'd0;

      case (state_q)
         S_POLL_WAIT: begin
            if (wait_q == '0) begin
               state_d = S_POLL_RD;
               xfer_d  = 1'b1;
               beg_d   = 1'b1;
               idx_d   = '0;
               to_d    = '0;
            end else begin
               wait_d = wait_q - 24'd1;
            end
         end
         S_COMMIT: begin
            state_d = S_POLL_WAIT;
            wait_d  = WAIT_LOAD;
         end
         S_ID_RD, S_CFG_WR, S_POLL_RD: begin
            if (xfer_q) begin
               if (!M_WAITREQUEST) begin
                  xfer_d = 1'b0;
                  gap_d  = 1'b1;
                  if (state_q == S_POLL_RD) sh_d[idx_q[1:0]] = M_READDATA;
                  if (state_q == S_ID_RD && M_READDATA != P_RTLID) begin
                     err_id_d = 1'b1;
                     state_d  = S_ERROR;
                     gap_d    = 1'b0;
                     stop_d   = 1'b0;
                  end else if (stop_q || STOP) begin
                     state_d = S_IDLE;
                     gap_d   = 1'b0;
                     stop_d  = 1'b0;
                  end
               end else if (to_q == TO_LAST) begin
                  xfer_d   = 1'b0;
                  err_to_d = 1'b1;
                  state_d  = S_ERROR;
                  stop_d   = 1'b0;
               end else begin
                  to_d = to_q + 8'd1;
                  if (STOP) stop_d = 1'b1;
               end
            end else if (gap_q) begin
               gap_d = 1'b0;
               if (idx_q != last_idx) begin
                  idx_d  = idx_q + 3'd1;
                  xfer_d = 1'b1;
                  beg_d  = 1'b1;
                  to_d   = '0;
               end else begin
                  case (state_q)
                     S_ID_RD: begin
                        state_d = S_CFG_WR;
                        idx_d   = '0;
                        xfer_d  = 1'b1;
                        beg_d   = 1'b1;
                        to_d    = '0;
                     end
                     S_CFG_WR: begin
                        state_d = S_POLL_WAIT;
                        wait_d  = WAIT_LOAD;
                     end
                     default: begin
                        state_d = S_COMMIT;
                        cnt_d   = sh_q;
                        snap_d  = 1'b1;
                     end
                  endcase
               end
            end else begin
               // Relaunch after a START aborted the previous transfer.
               xfer_d = 1'b1;
               beg_d  = 1'b1;
               to_d   = '0;
            end
         end
         default: ;
      endcase

      if (STOP && busy && !xfer_q) begin
         state_d = S_IDLE;
         xfer_d  = 1'b0;
         beg_d   = 1'b0;
         gap_d   = 1'b0;
         cnt_d   = cnt_q;
         snap_d  = 1'b0;
      end

      // An in-flight transfer is dropped for one idle cycle before the ID read.
      if (START) begin
         state_d  = S_ID_RD;
         xfer_d   = !xfer_q;
         beg_d    = !xfer_q;
         gap_d    = 1'b0;
         idx_d    = '0;
         to_d     = '0;
         stop_d   = 1'b0;
         err_id_d = 1'b0;
         err_to_d = 1'b0;
         low_d    = CFG_LOW_ADDR;
         high_d   = CFG_HIGH_ADDR;
         cnt_d    = cnt_q;
         snap_d   = 1'b0;
      end
   end

   always_comb begin
      bank = idx_q[0] ? high_q : low_q;
      case (idx_q[2:1])
         2'd0:    win = bank[23:0];
         2'd1:    win = bank[47:24];
         2'd2:    win = bank[71:48];
         default: win = bank[95:72];
      endcase
      M_ADDRESS = 16'h0000;
      if (xfer_q && state_q == S_CFG_WR)  M_ADDRESS = 16'h0018 + {11'd0, idx_q, 2'b00};
      if (xfer_q && state_q == S_POLL_RD) M_ADDRESS = 16'h0004 + {11'd0, idx_q, 2'b00};
   end

   assign M_CS            = xfer_q;
   assign M_BEGINTRANSFER = beg_q;
   assign M_WRITE         = xfer_q && (state_q == S_CFG_WR);
   assign M_READ          = xfer_q && (state_q != S_CFG_WR);
   assign M_WRITEDATA     = M_WRITE ? {8'd0, win} : 32'd0;
   assign BUSY            = busy;
   assign ERR_ID          = err_id_q;
   assign ERR_TIMEOUT     = err_to_q;
   assign SNAP_VALID      = snap_q;
   assign PRGEXCT_CNT     = cnt_q[0];
   assign RDSTAT_CNT      = cnt_q[1];
   assign BLKERS_CNT      = cnt_q[2];
   assign PDREAD_CNT      = cnt_q[3];

endmodule

// File: doc/ptmch_reg_poller.md
# ptmch_reg_poller

Avalon-MM master that drives the ptmch register slave from the initiator side. On START it reads and checks the RTL ID, then writes the four low/high page-address windows (PRGEXCT, RDSTAT, BLKERS, PDREAD). It then polls the four trigger-pulse counters every P_POLL_CYCLES and presents a coherent snapshot. It replaces CPU-driven register setup in headless test builds.

## Interface
- P_POLL_CYCLES, 100000, idle cycles between poll rounds (1 ms @ 100 MHz); legal 1..2^24-1
- P_TIMEOUT, 255, max consecutive WAITREQUEST-high cycles per transfer; legal 1..255
- P_RTLID, 32'h5A5A_00FF, expected value at slave offset 0x0000
- CLK100M  in  1  sole clock
- RESET  in  1  asynchronous, active-high reset
- START  in  1  one-cycle pulse; latches CFG_*, clears errors, starts sequence from any state
- STOP  in  1  one-cycle pulse; finish current transfer, go IDLE
- CFG_LOW_ADDR  in  96  {PDREAD,BLKERS,RDSTAT,PRGEXCT} low windows, 24 b each, [23:0]=PRGEXCT
- CFG_HIGH_ADDR  in  96  same packing, high windows
- PRGEXCT_CNT / RDSTAT_CNT / BLKERS_CNT / PDREAD_CNT  out  32 each  last committed snapshot
- SNAP_VALID  out  1  one-cycle pulse when all four counters update
- BUSY  out  1  high in every state except IDLE and ERROR
- ERR_ID  out  1  sticky; RTL ID mismatch
- ERR_TIMEOUT  out  1  sticky; WAITREQUEST timeout
- M_BEGINTRANSFER, M_CS, M_READ, M_WRITE  out  1 each  Avalon master strobes
- M_ADDRESS  out  16  byte address
- M_WRITEDATA  out  32  {8'd0, window}
- M_READDATA  in  32  valid in cycle WAITREQUEST is low with M_READ high
- M_WAITREQUEST  in  1  slave stall

## Operation
- States: IDLE, ID_RD, CFG_WR, POLL_WAIT, POLL_RD, COMMIT, ERROR.
- IDLE: strobes low. START -> ID_RD.
- ID_RD: read 0x0000. If data == P_RTLID -> CFG_WR, else set ERR_ID -> ERROR.
- CFG_WR: 8 writes in order 0x18,0x1C,0x20,0x24,0x28,0x2C,0x30,0x34 (PRGEXCT low, high, RDSTAT low, high, BLKERS, PDREAD), data from latched CFG -> POLL_WAIT.
- POLL_WAIT: down-counter loaded with P_POLL_CYCLES on entry; at 0 -> POLL_RD.
- POLL_RD: reads 0x04,0x08,0x0C,0x10 into shadow registers -> COMMIT.
- COMMIT: shadows copied to *_CNT in one cycle, SNAP_VALID=1 for that cycle -> POLL_WAIT.
- ERROR: strobes low, BUSY=0; left only by START or RESET.
- START in any state: abort any in-flight transfer (strobes drop next cycle), clear ERR_*, relatch CFG, -> ID_RD. *_CNT retained.
- STOP: if no transfer in flight -> IDLE next cycle; else complete the transfer, then IDLE. Partial POLL_RD does not commit. STOP with START in same cycle: START wins.
- Timeout: counter counts cycles with strobes asserted and WAITREQUEST high. On reaching P_TIMEOUT: drop strobes, set ERR_TIMEOUT, -> ERROR.

## Timing
- Reset: all outputs 0, state IDLE, counters cleared, CFG latch 0.
- Transfer: cycle T0 asserts M_CS, M_READ or M_WRITE, M_ADDRESS, M_WRITEDATA, and M_BEGINTRANSFER. BEGINTRANSFER is high in T0 only. All others hold until the edge at which M_WAITREQUEST=0 is sampled. Read data is captured at that edge.
- One idle cycle (all strobes low) after every transfer; strobes never high in two back-to-back transfers.
- With ptmch_reg (WAITREQUEST = BEGINTRANSFER & CS), each transfer is 2 cycles plus 1 idle: ID_RD 3, CFG_WR 24, POLL_RD 12, COMMIT 1.
- START to first SNAP_VALID: 1 + 3 + 24 + P_POLL_CYCLES + 12 + 1 cycles. Later rounds have period P_POLL_CYCLES + 13.
- M_READ and M_WRITE are never high together.

## Test plan
- Reset, then START with CFG_LOW={4{24'h000100}}, CFG_HIGH={4{24'h0001FF}} against a ptmch_reg model -> ID read, 8 writes with correct address/data order; slave readback of 0x18 = 0x00000100; BUSY=1.
- P_POLL_CYCLES=10, slave counters 1,2,3,4 -> SNAP_VALID at predicted cycle; PRGEXCT_CNT=1, RDSTAT_CNT=2, BLKERS_CNT=3, PDREAD_CNT=4; next pulse 23 cycles later.
- Slave ID returns 0x12345678 -> ERR_ID=1, no write strobes, BUSY=0. A later START with correct ID -> ERR_ID cleared.
- Slave holds WAITREQUEST high on 0x0C read, P_TIMEOUT=8 -> strobes drop after 8 stall cycles, ERR_TIMEOUT=1, *_CNT unchanged, no SNAP_VALID.
- Stretched WAITREQUEST of 3 cycles on every access -> address, data, and strobes stable throughout; BEGINTRANSFER only in the first cycle; results correct.
- STOP mid-POLL_RD -> current read completes, IDLE, no SNAP_VALID. RESET asserted mid-write -> all outputs 0 immediately.
